// File: rtl/fp_deco_pipe.sv
// fp_deco_pipe: registered IEEE-754-style operand decoder.
// Splits a packed float into sign / biased exponent / mantissa (hidden bit
// restored), classifies it (zero, subnormal, inf, NaN) and optionally flushes
// subnormals to a signed zero. A one-entry skid buffer behind the output
// register gives full throughput while keeping in_ready a pure register.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer of a valid beat holds it stable until the transfer. The
// outputs of an offered beat hold stable while out_valid && !out_ready.
// in_ready is registered and never depends combinationally on out_ready.
module fp_deco_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     Float_num,
  input  logic                     Modo_ftz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     Signo,
  output logic [EXP_W-1:0]         Exponente,
  output logic [MAN_W:0]           Mantissa,
  output logic                     Es_cero,
  output logic                     Es_subnormal,
  output logic                     Es_inf,
  output logic                     Es_nan,
  output logic [1:0]               dbg_state
);

  localparam int W = 1 + EXP_W + MAN_W;

  // EMPTY: nothing held; ONE: output register valid; FULL: skid also valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             is_zero;
    logic             is_sub;
    logic             is_inf;
    logic             is_nan;
  } beat_t;

  state_t           state;
  beat_t            or_q;
  beat_t            sk_q;
  beat_t            dec;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_frac;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;
  logic             accept;
  logic             move_out;

  assign in_exp    = Float_num[W-2:MAN_W];
  assign in_frac   = Float_num[MAN_W-1:0];
  assign exp_zero  = (in_exp == '0);
  assign exp_ones  = &in_exp;
  assign frac_zero = (in_frac == '0);

  assign accept    = in_valid && in_ready;
  assign move_out  = out_valid && out_ready;

  // Decode the incoming word; flush-to-zero rewrites only subnormal beats.
  always_comb begin
    dec         = '0;
    dec.sign    = Float_num[W-1];
    dec.exp     = in_exp;
    dec.man     = {~exp_zero, in_frac};
    dec.is_zero = exp_zero && frac_zero;
    dec.is_sub  = exp_zero && !frac_zero;
    dec.is_inf  = exp_ones && frac_zero;
    dec.is_nan  = exp_ones && !frac_zero;
    if (Modo_ftz && dec.is_sub) begin
      dec.exp     = '0;
      dec.man     = '0;
      dec.is_zero = 1'b1;
      dec.is_sub  = 1'b0;
    end
  end

  // Skid-buffer control: state, both data registers and the registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      or_q     <= '0;
      sk_q     <= '0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            or_q  <= dec;
            state <= ST_ONE;
          end
          in_ready <= 1'b1;
        end
        ST_ONE: begin
          if (accept && move_out) begin
            or_q     <= dec;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end else if (accept) begin
            sk_q     <= dec;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (move_out) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide with the drain.
          if (move_out) begin
            or_q     <= sk_q;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid    = (state != ST_EMPTY);
  assign Signo        = or_q.sign;
  assign Exponente    = or_q.exp;
  assign Mantissa     = or_q.man;
  assign Es_cero      = or_q.is_zero;
  assign Es_subnormal = or_q.is_sub;
  assign Es_inf       = or_q.is_inf;
  assign Es_nan       = or_q.is_nan;
  assign dbg_state    = state;

endmodule

// File: doc/fp_deco_pipe.md
# fp_deco_pipe

Parametrised, registered floating-point decoder. It splits a packed IEEE-754-style word into sign, biased exponent and mantissa with the implicit bit restored, and classifies the operand as zero, subnormal, infinity or NaN. An optional per-beat flush-to-zero mode is supported. It sits at the front of the FP datapath, between the operand source and the arithmetic stages. It uses a valid/ready handshake with a one-entry skid buffer, giving full throughput with a fully registered `in_ready`.

## Interface
- `EXP_W`, default 8: exponent field width (≥2).
- `MAN_W`, default 23: stored fraction width (≥1). Packed word width is W = 1+EXP_W+MAN_W.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat; registered.
- `Float_num`  in  W  packed operand: [W-1] sign, [W-2:MAN_W] exponent, [MAN_W-1:0] fraction.
- `Modo_ftz`  in  1  flush-to-zero for this beat; sampled together with `Float_num`.
- `out_valid`  out  1  decoded beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `Signo`  out  1  sign bit.
- `Exponente`  out  EXP_W  biased exponent field, unmodified except on flush.
- `Mantissa`  out  MAN_W+1  {hidden bit, fraction}.
- `Es_cero`, `Es_subnormal`, `Es_inf`, `Es_nan`  out  1 each  class flags; one-hot when classified, all 0 for normal numbers.

## Operation
- Accept: beat transfers when `in_valid && in_ready`.
- Move out: beat leaves when `out_valid && out_ready`.
- Decode (combinational on the input, registered with the beat):
  - Hidden bit = 1 if exponent ≠ 0, else 0.
  - exp==0, frac==0 → `Es_cero`.
  - exp==0, frac≠0 → `Es_subnormal`.
  - exp==all-ones, frac==0 → `Es_inf`.
  - exp==all-ones, frac≠0 → `Es_nan`.
  - Inf and NaN keep hidden bit 1. The NaN payload passes through unchanged.
- Flush-to-zero: `Modo_ftz`=1 on a subnormal beat drives `Mantissa`=0, `Exponente`=0, `Es_cero`=1, `Es_subnormal`=0, and keeps `Signo` (signed zero). `Modo_ftz` has no effect on other classes.
- Storage: one output register (OR) and one skid register (SK), each with a valid bit.
- States: EMPTY (OR invalid), ONE (OR valid, SK invalid), FULL (both valid).
  - EMPTY + accept → ONE.
  - ONE + accept + move-out → ONE (OR reloads).
  - ONE + accept, no move-out → FULL (beat goes to SK).
  - ONE + move-out, no accept → EMPTY.
  - FULL + move-out → ONE (SK→OR).
  - FULL never accepts.
- `in_ready` next = not(next state == FULL).
- Order is strictly FIFO. No beat is dropped or duplicated.
- While `in_valid`=0, `Float_num` and `Modo_ftz` are don't-care.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is on the outputs after edge N with `out_valid`=1.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` depends only on registers; no combinational path from `out_ready` to `in_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset, sampled at a rising edge with `rst`=1:
  - `out_valid`=0, `in_ready`=1, SK invalid.
  - `Signo`=0, `Exponente`=0, `Mantissa`=0, all flags 0.
  - Beats present during reset are discarded and no transfer occurs.
  - Reset mid-operation (ONE or FULL) empties both registers in that cycle.
- Simultaneous accept and move-out in FULL cannot occur, since `in_ready`=0.
- Simultaneous accept and move-out in ONE is a legal same-cycle reload.

## Test plan
- Default parameters, `out_ready`=1, send 0x3F800000 → one cycle later `Signo`=0, `Exponente`=0x7F, `Mantissa`=0x800000, all flags 0.
- Send 0x00000001 with `Modo_ftz`=0, then with `Modo_ftz`=1:
  - First beat → `Es_subnormal`=1, `Mantissa`=0x000001.
  - Second beat → `Es_cero`=1, `Mantissa`=0, `Exponente`=0.
  - Repeat with 0x80000001 and `Modo_ftz`=1 → `Signo`=1.
- Send 0xFF800000, 0x7FC00001, 0x00000000 back-to-back → in order:
  - `Es_inf` with `Signo`=1, `Mantissa`=0x800000.
  - `Es_nan` with `Mantissa`=0xC00001.
  - `Es_cero`.
  - `out_valid` high on 3 consecutive cycles.
- Backpressure: hold `out_ready`=0, drive 3 beats A, B, C continuously → A and B accepted, `in_ready`=0 from the cycle after B's accept, C held. Raise `out_ready` → A, B, C emerge in order, none lost.
- Assert `rst` for 1 cycle while FULL → next cycle `out_valid`=0, `in_ready`=1, outputs 0. A new beat then passes with 1-cycle latency.
- `EXP_W`=5, `MAN_W`=10:
  - 0x3C00 → `Exponente`=0x0F, `Mantissa`=0x400.
  - 0x7C00 → `Es_inf`.
  - 0x0200 → `Es_subnormal`, `Mantissa`=0x200.
